// File: rtl/matrix_feeder_if.sv
// Bus bundle between the matrix feeder, the operand memory read port and the
// systolic array edge. The master side is the feeder itself.
interface matrix_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    start;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic [3:0]              read_enable;
  logic [7:0]              read_elem;
  logic [4*DATA_WIDTH-1:0] mem_data;
  logic [4*DATA_WIDTH-1:0] feed_data;
  logic [3:0]              feed_valid;

  modport master (
    input  start,
    input  stall,
    input  mem_data,
    output busy,
    output done,
    output read_enable,
    output read_elem,
    output feed_data,
    output feed_valid
  );

  modport slave (
    output start,
    output stall,
    output mem_data,
    input  busy,
    input  done,
    input  read_enable,
    input  read_elem,
    input  feed_data,
    input  feed_valid
  );
endinterface

// File: rtl/matrix_feeder.sv
// Read-side sequencer for the 4x4 operand memory. Issues a diagonally skewed
// read wavefront (lane l starts l cycles after lane 0), registers the returned
// column data into per-lane feed registers and honours a downstream stall.
module matrix_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  matrix_feeder_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FW = 4 * DATA_WIDTH;

  state_t          state_r, state_s;
  logic [2:0]      t_r, t_s;
  logic [3:0]      read_enable_r, read_enable_s;
  logic [7:0]      read_elem_r, read_elem_s;
  logic [FW-1:0]   feed_data_r, feed_data_s;
  logic [3:0]      feed_valid_r, feed_valid_s;
  logic            done_r, done_s;

  // Read controls for wavefront step t: {enables[3:0], element indices[7:0]}.
  // Lane l is active for l <= t <= l+3 and then reads element t-l.
  function automatic logic [11:0] pattern(input logic [2:0] t);
    logic [3:0] en;
    logic [7:0] elem;
    int         ti;
    ti   = int'(t);
    en   = 4'b0000;
    elem = 8'h00;
    for (int l = 0; l < 4; l++) begin
      if ((ti >= l) && (ti <= l + 3)) begin
        en[l]          = 1'b1;
        elem[2*l +: 2] = 2'(ti - l);
      end else begin
        en[l]          = 1'b0;
        elem[2*l +: 2] = 2'b00;
      end
    end
    return {en, elem};
  endfunction

  // Lane-masked copy of the memory data: disabled lanes are forced to zero so
  // the array never sees stale or undefined read data.
  function automatic logic [FW-1:0] capture(input logic [3:0] en,
                                            input logic [FW-1:0] data);
    logic [FW-1:0] res;
    res = {FW{1'b0}};
    for (int l = 0; l < 4; l++) begin
      if (en[l]) begin
        res[DATA_WIDTH*l +: DATA_WIDTH] = data[DATA_WIDTH*l +: DATA_WIDTH];
      end else begin
        res[DATA_WIDTH*l +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
    return res;
  endfunction

  // Next-state, read-control and capture logic; everything holds on stall.
  always_comb begin
    state_s       = state_r;
    t_s           = t_r;
    read_enable_s = read_enable_r;
    read_elem_s   = read_elem_r;
    feed_data_s   = feed_data_r;
    feed_valid_s  = feed_valid_r;
    done_s        = 1'b0;

    case (state_r)
      IDLE: begin
        read_enable_s = 4'b0000;
        read_elem_s   = 8'h00;
        feed_data_s   = {FW{1'b0}};
        feed_valid_s  = 4'b0000;
        if (bus.start) begin
          state_s                      = RUN;
          t_s                          = 3'd0;
          {read_enable_s, read_elem_s} = pattern(3'd0);
        end else begin
          state_s = IDLE;
          t_s     = 3'd0;
        end
      end

      RUN: begin
        if (!bus.stall) begin
          feed_valid_s = read_enable_r;
          feed_data_s  = capture(read_enable_r, bus.mem_data);
          if (t_r < 3'd6) begin
            t_s                          = t_r + 3'd1;
            {read_enable_s, read_elem_s} = pattern(t_r + 3'd1);
          end else begin
            state_s       = DRAIN;
            read_enable_s = 4'b0000;
            read_elem_s   = 8'h00;
          end
        end else begin
          state_s = RUN;
        end
      end

      DRAIN: begin
        if (!bus.stall) begin
          feed_valid_s  = read_enable_r;
          feed_data_s   = capture(read_enable_r, bus.mem_data);
          read_enable_s = 4'b0000;
          read_elem_s   = 8'h00;
          state_s       = IDLE;
          t_s           = 3'd0;
          done_s        = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end

      default: begin
        state_s       = IDLE;
        t_s           = 3'd0;
        read_enable_s = 4'b0000;
        read_elem_s   = 8'h00;
        feed_data_s   = {FW{1'b0}};
        feed_valid_s  = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset aborts any feed without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      t_r           <= 3'd0;
      read_enable_r <= 4'b0000;
      read_elem_r   <= 8'h00;
      feed_data_r   <= {FW{1'b0}};
      feed_valid_r  <= 4'b0000;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      t_r           <= t_s;
      read_enable_r <= read_enable_s;
      read_elem_r   <= read_elem_s;
      feed_data_r   <= feed_data_s;
      feed_valid_r  <= feed_valid_s;
      done_r        <= done_s;
    end
  end

  assign bus.busy        = (state_r != IDLE);
  assign bus.done        = done_r;
  assign bus.read_enable = read_enable_r;
  assign bus.read_elem   = read_elem_r;
  assign bus.feed_data   = feed_data_r;
  assign bus.feed_valid  = feed_valid_r;

endmodule

// File: tb/tb_matrix_feeder.sv
// Scoreboard bench for matrix_feeder: the stimulus thread queues the expected
// feed beats for each matrix, a monitor pops and compares each fresh beat.
module tb_matrix_feeder;
  localparam int DW = 8;

  typedef struct packed {
    logic [3:0]      valid;
    logic [4*DW-1:0] data;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  fresh = 1'b0;
  beat_t exp_q[$];
  beat_t mon_b;
  int    checks = 0;
  int    errors = 0;
  int    exp_done = 0;
  int    seen_done = 0;

  matrix_feeder_if #(.DATA_WIDTH(DW)) bus ();

  matrix_feeder #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Operand memory model: mem[l][e] = 16*l + e, junk on disabled lanes.
  always_comb begin
    bus.mem_data = '0;
    for (int l = 0; l < 4; l++) begin
      if (bus.read_enable[l]) begin
        bus.mem_data[DW*l +: DW] = DW'(16 * l + int'(bus.read_elem[2*l +: 2]));
      end else begin
        bus.mem_data[DW*l +: DW] = 8'hEE;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected beats of one unstalled feed: beat k holds step t=k-1 reads.
  task automatic push_feed();
    beat_t b;
    for (int k = 1; k <= 7; k++) begin
      b = '0;
      for (int l = 0; l < 4; l++) begin
        if ((k - 1 >= l) && (k - 1 <= l + 3)) begin
          b.valid[l]       = 1'b1;
          b.data[DW*l +: DW] = DW'(16 * l + (k - 1 - l));
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic start_feed();
    bus.start = 1'b1;
    push_feed();
    tick();
    bus.start = 1'b0;
  endtask

  // A beat shown after an edge is new only if that edge was not stalled.
  always @(posedge clk) fresh <= !bus.stall;

  // Monitor: lane masking invariants, done counting and beat comparison.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) seen_done++;
      for (int l = 0; l < 4; l++) begin
        if (!bus.read_enable[l]) chk("elem_masked", 64'(bus.read_elem[2*l +: 2]), 64'd0);
        if (!bus.feed_valid[l]) chk("data_masked", 64'(bus.feed_data[DW*l +: DW]), 64'd0);
      end
      if (fresh && (bus.feed_valid != 4'b0000)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got valid %0h data %0h expected none", bus.feed_valid, bus.feed_data);
        end else begin
          mon_b = exp_q.pop_front();
          chk("beat_valid", 64'(bus.feed_valid), 64'(mon_b.valid));
          chk("beat_data", 64'(bus.feed_data), 64'(mon_b.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    tick(2);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ren", 64'(bus.read_enable), 64'd0);
    chk("rst_relem", 64'(bus.read_elem), 64'd0);
    chk("rst_fdata", 64'(bus.feed_data), 64'd0);
    chk("rst_fvalid", 64'(bus.feed_valid), 64'd0);
    rst = 1'b0;
    tick();

    // Feed 1: no stall, check read pattern and done timing.
    start_feed();
    chk("s0_busy", 64'(bus.busy), 64'd1);
    chk("s0_ren", 64'(bus.read_enable), 64'h1);
    chk("s0_relem", 64'(bus.read_elem), 64'h00);
    tick(3);
    chk("s3_ren", 64'(bus.read_enable), 64'hF);
    chk("s3_relem", 64'(bus.read_elem), 64'h1B);
    tick(3);
    chk("s6_ren", 64'(bus.read_enable), 64'h8);
    chk("s6_relem", 64'(bus.read_elem), 64'hC0);
    tick();
    chk("drain_busy", 64'(bus.busy), 64'd1);
    chk("drain_ren", 64'(bus.read_enable), 64'h0);
    chk("drain_done", 64'(bus.done), 64'd0);
    tick();
    chk("e8_done", 64'(bus.done), 64'd1);
    chk("e8_busy", 64'(bus.busy), 64'd0);
    exp_done++;
    tick();
    chk("e9_done", 64'(bus.done), 64'd0);

    // Feed 2: two stall cycles at step 2.
    start_feed();
    tick(2);
    bus.stall = 1'b1;
    tick();
    chk("stall1_ren", 64'(bus.read_enable), 64'h7);
    chk("stall1_relem", 64'(bus.read_elem), 64'h06);
    tick();
    chk("stall2_ren", 64'(bus.read_enable), 64'h7);
    chk("stall2_relem", 64'(bus.read_elem), 64'h06);
    bus.stall = 1'b0;
    tick(5);
    chk("stall_e9_done", 64'(bus.done), 64'd0);
    tick();
    chk("stall_e10_done", 64'(bus.done), 64'd1);
    exp_done++;
    tick();

    // Feed 3: start while busy is ignored, then back-to-back start.
    start_feed();
    tick(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_busy", 64'(bus.busy), 64'd1);
    tick(4);
    chk("ign_e8_done", 64'(bus.done), 64'd1);
    exp_done++;
    start_feed();
    chk("b2b_ren", 64'(bus.read_enable), 64'h1);
    chk("b2b_done", 64'(bus.done), 64'd0);
    tick(8);
    chk("b2b_e8_done", 64'(bus.done), 64'd1);
    exp_done++;
    tick();

    // Feed 5: reset during step 4 aborts; the next feed is complete.
    start_feed();
    tick(4);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ren", 64'(bus.read_enable), 64'd0);
    chk("mid_rst_relem", 64'(bus.read_elem), 64'd0);
    chk("mid_rst_fdata", 64'(bus.feed_data), 64'd0);
    chk("mid_rst_fvalid", 64'(bus.feed_valid), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick(2);
    chk("post_rst_done", 64'(bus.done), 64'd0);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    start_feed();
    tick(8);
    chk("rerun_done", 64'(bus.done), 64'd1);
    exp_done++;
    tick(2);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(seen_done), 64'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
